// File: rtl/fetch_ctrl_if.sv
// Fetch-control handshake bundle: hazard/redirect inputs, imem request/ack, pipeline enables and counters.
// The master side is the fetch controller; the slave side is the surrounding pipeline and memory.
interface fetch_ctrl_if;
  logic        PCSrcE;
  logic        StallReq;
  logic        imem_ack;
  logic        imem_req;
  logic        PCEnF;
  logic        EnD;
  logic        FlushD;
  logic        fetch_err;
  logic [15:0] fetch_cnt;
  logic [7:0]  flush_cnt;

  modport master (
    input  PCSrcE, StallReq, imem_ack,
    output imem_req, PCEnF, EnD, FlushD, fetch_err, fetch_cnt, flush_cnt
  );

  modport slave (
    output PCSrcE, StallReq, imem_ack,
    input  imem_req, PCEnF, EnD, FlushD, fetch_err, fetch_cnt, flush_cnt
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch controller: boot delay, imem request sequencing, redirect/stall handling, ack-timeout trap.
// Latency: enables are zero-latency decodes of state+inputs; imem_req is a pure state decode.
// Backpressure: StallReq or a redirect parks the fetch in HOLD (request dropped) until it may resume.
module fetch_ctrl #(
  parameter int BOOT_CYCLES = 2,
  parameter int ACK_TIMEOUT = 16
) (
  input logic         clk,
  input logic         rst,
  fetch_ctrl_if.master bus
);

  typedef enum logic [1:0] {BOOT, REQ, HOLD, ERR} state_t;

  localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);
  localparam logic [7:0] TO_LAST   = 8'(ACK_TIMEOUT - 1);

  state_t      state, stateNxt;
  logic [3:0]  bootCnt, bootCntNxt;
  logic [7:0]  toCnt, toCntNxt;
  logic [15:0] fetchCnt;
  logic [7:0]  flushCnt;
  logic        pcEn, capEn, flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= BOOT;
      bootCnt <= '0;
      toCnt   <= '0;
    end else begin
      state   <= stateNxt;
      bootCnt <= bootCntNxt;
      toCnt   <= toCntNxt;
    end
  end

  always_comb begin
    stateNxt   = state;
    bootCntNxt = bootCnt;
    toCntNxt   = '0;
    pcEn       = 1'b0;
    capEn      = 1'b0;
    flush      = 1'b0;
    case (state)
      BOOT: begin
        if (bootCnt == BOOT_LAST) begin
          stateNxt   = REQ;
          bootCntNxt = '0;
        end else begin
          bootCntNxt = bootCnt + 4'd1;
        end
      end
      REQ: begin
        // Redirect beats stall beats ack; an ack arriving with a redirect is dropped.
        if (bus.PCSrcE) begin
          pcEn     = 1'b1;
          flush    = 1'b1;
          stateNxt = HOLD;
        end else if (bus.StallReq) begin
          stateNxt = HOLD;
        end else if (bus.imem_ack) begin
          pcEn  = 1'b1;
          capEn = 1'b1;
        end else if (toCnt == TO_LAST) begin
          stateNxt = ERR;
        end else begin
          toCntNxt = toCnt + 8'd1;
        end
      end
      HOLD: begin
        if (bus.PCSrcE) begin
          pcEn  = 1'b1;
          flush = 1'b1;
        end else if (!bus.StallReq) begin
          stateNxt = REQ;
        end
      end
      ERR: begin
        stateNxt = ERR;
      end
      default: begin
        stateNxt = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetchCnt <= '0;
      flushCnt <= '0;
    end else begin
      if (capEn) fetchCnt <= fetchCnt + 16'd1;
      if (flush && (flushCnt != 8'hFF)) flushCnt <= flushCnt + 8'd1;
    end
  end

  assign bus.imem_req  = (state == REQ);
  assign bus.PCEnF     = pcEn;
  assign bus.EnD       = capEn;
  assign bus.FlushD    = flush;
  assign bus.fetch_err = (state == ERR);
  assign bus.fetch_cnt = fetchCnt;
  assign bus.flush_cnt = flushCnt;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: vector table, directed corner sequences, and randomized run against a reference model.
module tb_fetch_ctrl;
  localparam int BOOT_CYCLES = 2;
  localparam int ACK_TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst;
  int   nChecks = 0;
  int   nFails  = 0;

  fetch_ctrl_if bus();

  fetch_ctrl #(.BOOT_CYCLES(BOOT_CYCLES), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    bit p, s, a;
    bit eReq, ePc, eEn, eFl;
  } vec_t;

  vec_t vecs [0:13];

  // Reference: cycles left in boot, whether parked, whether trapped, ack wait length.
  int mBootLeft, mWaited, mFetch, mFlush;
  bit mHold, mDead;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input bit p, input bit s, input bit a);
    bus.PCSrcE   = p;
    bus.StallReq = s;
    bus.imem_ack = a;
  endtask

  task automatic apply(input bit p, input bit s, input bit a);
    drive(p, s, a);
    @(negedge clk);
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic modelReset();
    mBootLeft = BOOT_CYCLES;
    mWaited   = 0;
    mHold     = 1'b0;
    mDead     = 1'b0;
    mFetch    = 0;
    mFlush    = 0;
  endtask

  task automatic doReset();
    #2;
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    #1;
    check("rst imem_req", bus.imem_req, 0);
    check("rst PCEnF", bus.PCEnF, 0);
    check("rst EnD", bus.EnD, 0);
    check("rst FlushD", bus.FlushD, 0);
    check("rst fetch_err", bus.fetch_err, 0);
    check("rst fetch_cnt", bus.fetch_cnt, 0);
    check("rst flush_cnt", bus.flush_cnt, 0);
    modelReset();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic modelCycle(input bit p, input bit s, input bit a);
    bit live, busy, redirect, capture;
    live     = (mBootLeft == 0) && !mDead;
    busy     = live && !mHold;
    redirect = live && p;
    capture  = busy && !p && !s && a;
    check("rnd imem_req", bus.imem_req, busy);
    check("rnd PCEnF", bus.PCEnF, redirect || capture);
    check("rnd EnD", bus.EnD, capture);
    check("rnd FlushD", bus.FlushD, redirect);
    check("rnd fetch_err", bus.fetch_err, mDead);
    check("rnd fetch_cnt", bus.fetch_cnt, mFetch);
    check("rnd flush_cnt", bus.flush_cnt, mFlush);
    if (mBootLeft > 0) begin
      mBootLeft--;
    end else if (!mDead) begin
      if (mHold) begin
        mHold = p || s;
      end else if (p || s) begin
        mHold   = 1'b1;
        mWaited = 0;
      end else if (a) begin
        mWaited = 0;
      end else begin
        mWaited++;
        if (mWaited == ACK_TIMEOUT) mDead = 1'b1;
      end
    end
    if (capture) mFetch = (mFetch + 1) % 65536;
    if (redirect && mFlush < 255) mFlush++;
  endtask

  initial begin
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0);

    //             p  s  a   req pc en fl
    vecs[0]  = '{1, 0, 1,  0, 0, 0, 0};
    vecs[1]  = '{0, 0, 1,  0, 0, 0, 0};
    vecs[2]  = '{0, 0, 1,  1, 1, 1, 0};
    vecs[3]  = '{0, 0, 1,  1, 1, 1, 0};
    vecs[4]  = '{1, 0, 1,  1, 1, 0, 1};
    vecs[5]  = '{0, 0, 1,  0, 0, 0, 0};
    vecs[6]  = '{1, 1, 0,  1, 1, 0, 1};
    vecs[7]  = '{0, 1, 0,  0, 0, 0, 0};
    vecs[8]  = '{1, 1, 0,  0, 1, 0, 1};
    vecs[9]  = '{0, 0, 0,  0, 0, 0, 0};
    vecs[10] = '{0, 1, 1,  1, 0, 0, 0};
    vecs[11] = '{0, 0, 0,  0, 0, 0, 0};
    vecs[12] = '{0, 0, 0,  1, 0, 0, 0};
    vecs[13] = '{0, 0, 1,  1, 1, 1, 0};

    #3;
    doReset();
    for (int i = 0; i < 14; i++) begin
      apply(vecs[i].p, vecs[i].s, vecs[i].a);
      check($sformatf("vec%0d imem_req", i), bus.imem_req, vecs[i].eReq);
      check($sformatf("vec%0d PCEnF", i), bus.PCEnF, vecs[i].ePc);
      check($sformatf("vec%0d EnD", i), bus.EnD, vecs[i].eEn);
      check($sformatf("vec%0d FlushD", i), bus.FlushD, vecs[i].eFl);
      advance();
    end
    check("vec fetch_cnt", bus.fetch_cnt, 3);
    check("vec flush_cnt", bus.flush_cnt, 3);

    // Boot delay with ack tied high, then back-to-back captures.
    doReset();
    for (int i = 0; i < BOOT_CYCLES; i++) begin
      apply(1'b0, 1'b0, 1'b1);
      check("boot imem_req", bus.imem_req, 0);
      check("boot EnD", bus.EnD, 0);
      advance();
    end
    for (int i = 0; i < 5; i++) begin
      apply(1'b0, 1'b0, 1'b1);
      check("b2b imem_req", bus.imem_req, 1);
      check("b2b PCEnF", bus.PCEnF, 1);
      check("b2b EnD", bus.EnD, 1);
      advance();
    end
    check("b2b fetch_cnt", bus.fetch_cnt, 5);

    // Ack timeout trap, inputs ignored afterwards, cleared only by reset.
    doReset();
    for (int i = 0; i < BOOT_CYCLES; i++) begin
      apply(1'b0, 1'b0, 1'b0);
      advance();
    end
    for (int i = 0; i < ACK_TIMEOUT; i++) begin
      apply(1'b0, 1'b0, 1'b0);
      check("wait imem_req", bus.imem_req, 1);
      check("wait fetch_err", bus.fetch_err, 0);
      advance();
    end
    apply(1'b0, 1'b0, 1'b0);
    check("err fetch_err", bus.fetch_err, 1);
    check("err imem_req", bus.imem_req, 0);
    advance();
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, 1'b0, 1'b1);
      check("err PCEnF", bus.PCEnF, 0);
      check("err FlushD", bus.FlushD, 0);
      check("err EnD", bus.EnD, 0);
      advance();
    end
    check("err fetch_cnt", bus.fetch_cnt, 0);
    check("err flush_cnt", bus.flush_cnt, 0);
    check("err sticky", bus.fetch_err, 1);

    // Redirect saturation and capture counter wrap.
    doReset();
    for (int i = 0; i < BOOT_CYCLES; i++) begin
      apply(1'b0, 1'b0, 1'b0);
      advance();
    end
    for (int i = 0; i < 300; i++) begin
      apply(1'b1, 1'b0, 1'b0);
      advance();
    end
    check("sat flush_cnt", bus.flush_cnt, 255);
    drive(1'b0, 1'b0, 1'b1);
    advance();
    repeat (65537) @(posedge clk);
    #1;
    check("wrap fetch_cnt", bus.fetch_cnt, 1);
    check("wrap flush_cnt", bus.flush_cnt, 255);

    // Randomized run; segments sweep ack density so the timeout trap is reached too.
    for (int seg = 0; seg < 4; seg++) begin
      int ackPct, evPct;
      ackPct = (seg == 0) ? 90 : (seg == 1) ? 50 : (seg == 2) ? 15 : 3;
      evPct  = (seg == 3) ? 1 : 8;
      doReset();
      for (int i = 0; i < 500; i++) begin
        bit p, s, a;
        p = ($urandom_range(0, 99) < evPct);
        s = ($urandom_range(0, 99) < evPct + 4);
        a = ($urandom_range(0, 99) < ackPct);
        apply(p, s, a);
        modelCycle(p, s, a);
        advance();
        if ($urandom_range(0, 249) == 0) doReset();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
